// File: rtl/matrix_slot_writer.sv
// Writes one matrix (metadata word + row-major elements) into a fixed-size BRAM slot.
// Define MATRIX_WRITER_COMMIT_LAST_EN to blank the metadata first and commit it after the last element.
//
// state  | meaning
// IDLE   | waiting for start
// CHECK  | size/slot validation, base and count captured
// INVAL  | metadata word cleared (commit-last build only)
// META   | metadata word written
// STREAM | accepting elements, one write per beat
// COMMIT | metadata word written after elements (commit-last build only)
// DONE   | completion pulse issued, back to IDLE
module matrix_slot_writer #(
  parameter int BLOCK_SIZE = 1152,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            slot_id,
  input  logic [7:0]            rows,
  input  logic [7:0]            cols,
  input  logic [31:0]           in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [31:0]           bram_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_INVAL, S_META, S_STREAM, S_COMMIT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [2:0]            slot_q;
  logic [7:0]            rows_q;
  logic [7:0]            cols_q;
  logic [15:0]           count_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [15:0]           idx_q;
  logic                  err_q;

  logic [15:0]           count_c;
  logic [ADDR_WIDTH-1:0] base_c;
  logic                  reject_c;
  logic                  beat;
  logic                  last_beat;

  assign count_c   = {8'h00, rows_q} * {8'h00, cols_q};
  assign base_c    = ADDR_WIDTH'(slot_q) * ADDR_WIDTH'(BLOCK_SIZE);
  assign reject_c  = (rows_q == 8'd0) || (cols_q == 8'd0) || (count_c > 16'(BLOCK_SIZE - 1));
  assign in_ready  = (state == S_STREAM);
  assign beat      = in_valid & in_ready;
  assign last_beat = beat && (idx_q == count_q - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_CHECK;
      S_CHECK: begin
        if (reject_c) state_nxt = S_DONE;
`ifdef MATRIX_WRITER_COMMIT_LAST_EN
        else          state_nxt = S_INVAL;
`else
        else          state_nxt = S_META;
`endif
      end
      S_INVAL:  state_nxt = S_STREAM;
      S_META:   state_nxt = S_STREAM;
      S_STREAM: begin
`ifdef MATRIX_WRITER_COMMIT_LAST_EN
        if (last_beat) state_nxt = S_COMMIT;
`else
        if (last_beat) state_nxt = S_DONE;
`endif
      end
      S_COMMIT: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q     <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      count_q    <= '0;
      base_q     <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      bram_we <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            slot_q <= slot_id;
            rows_q <= rows;
            cols_q <= cols;
            idx_q  <= '0;
            err_q  <= 1'b0;
            busy   <= 1'b1;
          end
        end
        S_CHECK: begin
          count_q <= count_c;
          base_q  <= base_c;
          err_q   <= reject_c;
        end
        // Blank metadata keeps a half-written slot invisible to the scanner.
        S_INVAL: begin
          bram_we    <= 1'b1;
          bram_addr  <= base_q;
          bram_wdata <= 32'h0;
        end
        S_META, S_COMMIT: begin
          bram_we    <= 1'b1;
          bram_addr  <= base_q;
          bram_wdata <= {rows_q, cols_q, 16'h0000};
        end
        S_STREAM: begin
          if (beat) begin
            bram_we    <= 1'b1;
            bram_addr  <= base_q + ADDR_WIDTH'(idx_q) + ADDR_WIDTH'(1);
            bram_wdata <= in_data;
            idx_q      <= idx_q + 16'd1;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          error <= err_q;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
